// File: rtl/lift_pkg.sv
// Shared types and helpers for the lift door sequencer.
package lift_pkg;

  typedef enum logic [1:0] {
    DOOR_IDLE,
    DOOR_OPENING,
    DOOR_OPEN,
    DOOR_CLOSING
  } door_state_e;

  // Widest LED bar floor_onehot can produce; callers truncate to their width.
  localparam int unsigned MaxFloors = 256;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_val-1, never less than one.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic logic [MaxFloors-1:0] floor_onehot(int unsigned floor, int unsigned n);
    logic [MaxFloors-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < MaxFloors; i++) begin
      oh[i] = (i == floor) && (i < n);
    end
    return oh;
  endfunction

endpackage

// File: rtl/lift_door_ctrl_if.sv
// Scheduler/panel-facing signal bundle of the door sequencer.
// Optional obstruct input exists only when LIFT_DOOR_OBSTRUCT_EN is defined.
interface lift_door_ctrl_if #(
  parameter int unsigned NUM_FLOORS = 16,
  parameter int unsigned FLOOR_W    = 4
);
  logic                  open_req;
  logic                  close_req;
  logic                  hold_req;
  logic [FLOOR_W-1:0]    lift_num;
`ifdef LIFT_DOOR_OBSTRUCT_EN
  logic                  obstruct;
`endif
  logic [NUM_FLOORS-1:0] led;
  logic                  door_open;
  logic                  door_busy;
  logic                  closed_pls;
  logic                  bad_floor;

  modport master (
`ifdef LIFT_DOOR_OBSTRUCT_EN
    output obstruct,
`endif
    output open_req, close_req, hold_req, lift_num,
    input  led, door_open, door_busy, closed_pls, bad_floor
  );

  modport slave (
`ifdef LIFT_DOOR_OBSTRUCT_EN
    input  obstruct,
`endif
    input  open_req, close_req, hold_req, lift_num,
    output led, door_open, door_busy, closed_pls, bad_floor
  );
endinterface

// File: rtl/lift_led_blinker.sv
// Free-running LED blink phase; restart forces the lit half and realigns the period.
module lift_led_blinker
  import lift_pkg::*;
#(
  parameter int unsigned BLINK_CYC = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic blink
);
  localparam int unsigned CntW = cnt_width(BLINK_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_CYC - 1);

  logic [CntW-1:0] cnt_q;
  logic            blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else if (restart) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_q   <= '0;
      blink_q <= ~blink_q;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign blink = blink_q;
endmodule

// File: rtl/lift_door_ctrl.sv
// Per-car door sequencer: IDLE/OPENING/OPEN/CLOSING under timers, one-hot floor LED bar.
// Define LIFT_DOOR_OBSTRUCT_EN to add the obstruct input (reopen / dwell hold).
module lift_door_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 16,
  parameter int unsigned FLOOR_W    = 4,
  parameter int unsigned MOVE_CYC   = 100,
  parameter int unsigned OPEN_CYC   = 500,
  parameter int unsigned BLINK_CYC  = 25
) (
  input logic             clk,
  input logic             rst_n,
  lift_door_ctrl_if.slave bus
);
  localparam int unsigned TimerW = cnt_width(max3(MOVE_CYC, OPEN_CYC, BLINK_CYC));
  localparam logic [TimerW-1:0] MoveLast = TimerW'(MOVE_CYC - 1);
  localparam logic [TimerW-1:0] OpenLast = TimerW'(OPEN_CYC - 1);

  door_state_e           state_q;
  logic [FLOOR_W-1:0]    floor_q;
  logic [TimerW-1:0]     timer_q;
  logic                  closed_evt_q;
  logic [NUM_FLOORS-1:0] led_q;
  logic                  door_open_q, door_busy_q, closed_pls_q, bad_floor_q;

  logic obstruct;
`ifdef LIFT_DOOR_OBSTRUCT_EN
  assign obstruct = bus.obstruct;
`else
  assign obstruct = 1'b0;
`endif

  logic floor_ok, start_ok, bad_req, reload, to_closing, reopen, restart, blink;
  logic [NUM_FLOORS-1:0] floor_oh, led_now;

  assign floor_ok   = 32'(bus.lift_num) < NUM_FLOORS;
  assign start_ok   = (state_q == DOOR_IDLE) && bus.open_req && floor_ok;
  assign bad_req    = (state_q == DOOR_IDLE) && bus.open_req && !floor_ok;
  // Hold (or obstruction) wins over close when both arrive together.
  assign reload     = bus.hold_req || obstruct;
  assign to_closing = (state_q == DOOR_OPEN) && !reload && (bus.close_req || timer_q == '0);
  assign reopen     = (state_q == DOOR_CLOSING) && (bus.open_req || bus.hold_req || obstruct);
  assign restart    = start_ok || to_closing || reopen;

  lift_led_blinker #(
    .BLINK_CYC(BLINK_CYC)
  ) u_blinker (
    .clk    (clk),
    .rst_n  (rst_n),
    .restart(restart),
    .blink  (blink)
  );

  assign floor_oh = NUM_FLOORS'(floor_onehot(32'(floor_q), NUM_FLOORS));

  always_comb begin
    led_now = '0;
    unique case (state_q)
      DOOR_IDLE:    led_now = '0;
      DOOR_OPEN:    led_now = floor_oh;
      default:      led_now = floor_oh & {NUM_FLOORS{blink}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DOOR_IDLE;
      floor_q      <= '0;
      timer_q      <= '0;
      closed_evt_q <= 1'b0;
      led_q        <= '0;
      door_open_q  <= 1'b0;
      door_busy_q  <= 1'b0;
      closed_pls_q <= 1'b0;
      bad_floor_q  <= 1'b0;
    end else begin
      led_q        <= led_now;
      door_open_q  <= (state_q == DOOR_OPEN);
      door_busy_q  <= (state_q != DOOR_IDLE);
      closed_pls_q <= closed_evt_q;
      bad_floor_q  <= bad_req;
      closed_evt_q <= 1'b0;
      unique case (state_q)
        DOOR_IDLE: begin
          if (start_ok) begin
            state_q <= DOOR_OPENING;
            floor_q <= bus.lift_num;
            timer_q <= MoveLast;
          end
        end
        DOOR_OPENING: begin
          if (timer_q == '0) begin
            state_q <= DOOR_OPEN;
            timer_q <= OpenLast;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        DOOR_OPEN: begin
          if (reload) begin
            timer_q <= OpenLast;
          end else if (to_closing) begin
            state_q <= DOOR_CLOSING;
            timer_q <= MoveLast;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        DOOR_CLOSING: begin
          if (reopen) begin
            // Reverse from the current leaf position rather than restarting the stroke.
            state_q <= DOOR_OPENING;
            timer_q <= MoveLast - timer_q;
          end else if (timer_q == '0) begin
            state_q      <= DOOR_IDLE;
            closed_evt_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TimerW'(1);
          end
        end
        default: state_q <= DOOR_IDLE;
      endcase
    end
  end

  assign bus.led        = led_q;
  assign bus.door_open  = door_open_q;
  assign bus.door_busy  = door_busy_q;
  assign bus.closed_pls = closed_pls_q;
  assign bus.bad_floor  = bad_floor_q;
endmodule

// File: tb/tb_lift_door_ctrl.sv
// Directed bench for lift_door_ctrl: per-cycle expected outputs queued, popped after each edge.
module tb_lift_door_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lift_door_ctrl_if #(.NUM_FLOORS(16), .FLOOR_W(4)) bus_a ();
  lift_door_ctrl_if #(.NUM_FLOORS(12), .FLOOR_W(4)) bus_b ();

  lift_door_ctrl #(
    .NUM_FLOORS(16), .FLOOR_W(4), .MOVE_CYC(4), .OPEN_CYC(8), .BLINK_CYC(2)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a.slave)
  );

  lift_door_ctrl #(
    .NUM_FLOORS(12), .FLOOR_W(4), .MOVE_CYC(4), .OPEN_CYC(8), .BLINK_CYC(2)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b.slave)
  );

  typedef struct packed {
    logic [15:0] led;
    logic        door_open;
    logic        door_busy;
    logic        closed_pls;
    logic        bad_floor;
  } exp_t;

  exp_t  q_a[$];
  exp_t  q_b[$];
  string phase;
  int    n_run = 0;
  int    n_fail = 0;

  task automatic push_a(int n, logic [15:0] led, logic op, logic busy, logic pls, logic bad);
    exp_t e;
    e = '{led: led, door_open: op, door_busy: busy, closed_pls: pls, bad_floor: bad};
    repeat (n) q_a.push_back(e);
  endtask

  task automatic push_b(int n, logic [15:0] led, logic op, logic busy, logic pls, logic bad);
    exp_t e;
    e = '{led: led, door_open: op, door_busy: busy, closed_pls: pls, bad_floor: bad};
    repeat (n) q_b.push_back(e);
  endtask

  // Moving door: lit for two clocks, dark for two (BLINK_CYC=2, MOVE_CYC=4).
  task automatic blink_a(logic [15:0] oh);
    push_a(2, oh, 1'b0, 1'b1, 1'b0, 1'b0);
    push_a(2, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic blink_b(logic [15:0] oh);
    push_b(2, oh, 1'b0, 1'b1, 1'b0, 1'b0);
    push_b(2, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_q();
    exp_t e;
    exp_t obs;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      obs = '{led: bus_a.led, door_open: bus_a.door_open, door_busy: bus_a.door_busy,
              closed_pls: bus_a.closed_pls, bad_floor: bus_a.bad_floor};
      n_run++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s dut_a: led/open/busy/pls/bad observed=%h/%b/%b/%b/%b expected=%h/%b/%b/%b/%b",
               phase, obs.led, obs.door_open, obs.door_busy, obs.closed_pls, obs.bad_floor,
               e.led, e.door_open, e.door_busy, e.closed_pls, e.bad_floor);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      obs = '{led: {4'h0, bus_b.led}, door_open: bus_b.door_open, door_busy: bus_b.door_busy,
              closed_pls: bus_b.closed_pls, bad_floor: bus_b.bad_floor};
      n_run++;
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s dut_b: led/open/busy/pls/bad observed=%h/%b/%b/%b/%b expected=%h/%b/%b/%b/%b",
               phase, obs.led, obs.door_open, obs.door_busy, obs.closed_pls, obs.bad_floor,
               e.led, e.door_open, e.door_busy, e.closed_pls, e.bad_floor);
      end
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_q();
    end
  endtask

  // Plain open at a floor: idle, 4 blink, 8 solid, 4 blink, closed pulse, idle.
  task automatic plain_cycle_a(logic [15:0] oh);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(oh);
    push_a(8, oh, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_a(oh);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.open_req = 0; bus_a.close_req = 0; bus_a.hold_req = 0; bus_a.lift_num = '0;
    bus_b.open_req = 0; bus_b.close_req = 0; bus_b.hold_req = 0; bus_b.lift_num = '0;
`ifdef LIFT_DOOR_OBSTRUCT_EN
    bus_a.obstruct = 0;
    bus_b.obstruct = 0;
`endif
    phase = "reset";
    #12;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_q();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    phase = "floor5_plain";
    bus_a.lift_num = 4'd5; bus_a.open_req = 1;
    plain_cycle_a(16'h0020);
    tick(1);
    bus_a.open_req = 0;
    tick(18);

    phase = "floor15_plain";
    bus_a.lift_num = 4'd15; bus_a.open_req = 1;
    plain_cycle_a(16'h8000);
    tick(1);
    bus_a.open_req = 0;
    tick(18);

    phase = "floor0_close_early";
    bus_a.lift_num = 4'd0; bus_a.open_req = 1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(16'h0001);
    push_a(3, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_a(16'h0001);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_a.open_req = 0;
    tick(6);
    bus_a.close_req = 1;
    tick(1);
    bus_a.close_req = 0;
    tick(6);

    phase = "hold_extend";
    bus_a.lift_num = 4'd7; bus_a.open_req = 1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(16'h0080);
    push_a(16, 16'h0080, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_a(16'h0080);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_a.open_req = 0;
    tick(9);
    bus_a.hold_req = 1;
    tick(1);
    bus_a.hold_req = 0;
    tick(1);
    bus_a.hold_req = 1; bus_a.close_req = 1;
    tick(1);
    bus_a.hold_req = 0; bus_a.close_req = 0;
    tick(14);

    phase = "reopen_while_closing";
    bus_a.lift_num = 4'd5; bus_a.open_req = 1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(16'h0020);
    push_a(8, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0);
    push_a(2, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0);
    push_a(8, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_a(16'h0020);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_a.open_req = 0;
    tick(12);
    bus_a.lift_num = 4'd9; bus_a.open_req = 1;
    tick(1);
    bus_a.open_req = 0;
    tick(15);

    phase = "bad_floor";
    bus_b.lift_num = 4'd13; bus_b.open_req = 1;
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_b.open_req = 0;
    tick(1);
    bus_b.lift_num = 4'd12; bus_b.open_req = 1;
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_b.open_req = 0;
    tick(1);

    phase = "floor11_top_of_12";
    bus_b.lift_num = 4'd11; bus_b.open_req = 1;
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_b(16'h0800);
    push_b(8, 16'h0800, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_b(16'h0800);
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_b(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_b.open_req = 0;
    tick(18);

    phase = "async_reset_in_open";
    bus_a.lift_num = 4'd3; bus_a.open_req = 1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(16'h0008);
    push_a(3, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1);
    bus_a.open_req = 0;
    tick(7);
    #2;
    rst_n = 1'b0;
    #1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_q();
    @(negedge clk);
    rst_n = 1'b1;
    phase = "idle_after_reset";
    push_a(3, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(3);

`ifdef LIFT_DOOR_OBSTRUCT_EN
    phase = "obstruct";
    bus_a.lift_num = 4'd2; bus_a.open_req = 1;
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    blink_a(16'h0004);
    push_a(10, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
    push_a(2, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0);
    push_a(8, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0);
    blink_a(16'h0004);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_a(1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    bus_a.open_req = 0;
    tick(5);
    bus_a.obstruct = 1; bus_a.close_req = 1;
    tick(1);
    bus_a.obstruct = 0; bus_a.close_req = 0;
    tick(8);
    bus_a.obstruct = 1;
    tick(1);
    bus_a.obstruct = 0;
    tick(15);
`endif

    phase = "queues_drained";
    n_run++;
    assert (q_a.size() + q_b.size() === 0) else begin
      n_fail++;
      $error("FAIL %s: observed %0d pending entries, expected 0", phase, q_a.size() + q_b.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
